fir_stim_gen: RTL and testbench

FIR_STIM_GEN -- requirements
Module: fir_stim_gen

---
 rtl/fir_stim_gen.sv | 150 +++++++++++++++
 tb/tb_fir_stim_gen.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_stim_gen.sv
// fir_stim_gen: burst stimulus source for a FIR input port.
// Produces impulse, step, ramp or LFSR-noise bursts of a programmable
// length over a valid/ready handshake, with abort and a done pulse.
module fir_stim_gen #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] amp,
    input  logic [LEN_W-1:0]  len,
    input  logic [15:0]       seed,
    input  logic              abort,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  sample_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0]  MODE_IMPULSE = 2'd0;
    localparam logic [1:0]  MODE_STEP    = 2'd1;
    localparam logic [1:0]  MODE_RAMP    = 2'd2;
    localparam logic [15:0] LFSR_INIT    = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;

    state_t              state_reg;
    state_t              state_next;

    // Burst parameters captured at start; later input changes are ignored.
    logic [1:0]          mode_reg;
    logic [DATA_W-1:0]   amp_reg;
    logic [LEN_W-1:0]    len_reg;

    logic [15:0]         lfsr_reg;
    logic [DATA_W-1:0]   data_reg;
    logic                last_reg;
    logic [LEN_W-1:0]    cnt_reg;

    logic                transfer;
    logic [15:0]         seed_eff;
    logic [15:0]         lfsr_step;
    logic [DATA_W-1:0]   first_sample;
    logic [DATA_W-1:0]   next_sample;
    logic [LEN_W-1:0]    cnt_inc;
    logic [LEN_W-1:0]    len_m1;

    // Handshake, LFSR step and candidate samples for the datapath.
    always_comb begin
        transfer  = (state_reg == ST_RUN) && out_ready;
        seed_eff  = (seed == 16'h0000) ? LFSR_INIT : seed;
        lfsr_step = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? LFSR_TAPS : 16'h0000);
        cnt_inc   = cnt_reg + 1'b1;
        len_m1    = len_reg - 1'b1;

        case (mode)
            MODE_IMPULSE: first_sample = amp;
            MODE_STEP:    first_sample = amp;
            MODE_RAMP:    first_sample = '0;
            default:      first_sample = seed_eff[DATA_W-1:0];
        endcase

        // Ramp accumulates from the current sample so wrap-around is free.
        case (mode_reg)
            MODE_IMPULSE: next_sample = '0;
            MODE_STEP:    next_sample = amp_reg;
            MODE_RAMP:    next_sample = data_reg + amp_reg;
            default:      next_sample = lfsr_step[DATA_W-1:0];
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_next = state_reg;
        out_valid  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = (len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (abort || (transfer && last_reg)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Sample datapath: load the first sample at start, advance on each transfer.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mode_reg <= '0;
            amp_reg  <= '0;
            len_reg  <= '0;
            lfsr_reg <= LFSR_INIT;
            data_reg <= '0;
            last_reg <= 1'b0;
            cnt_reg  <= '0;
        end else if ((state_reg == ST_IDLE) && start) begin
            mode_reg <= mode;
            amp_reg  <= amp;
            len_reg  <= len;
            lfsr_reg <= seed_eff;
            data_reg <= first_sample;
            last_reg <= (len == LEN_W'(1));
            cnt_reg  <= '0;
        end else if (transfer) begin
            lfsr_reg <= lfsr_step;
            data_reg <= next_sample;
            last_reg <= (cnt_inc == len_m1);
            cnt_reg  <= cnt_inc;
        end
    end

    assign out_data   = data_reg;
    assign out_last   = last_reg && (state_reg == ST_RUN);
    assign sample_cnt = cnt_reg;

endmodule

// File: tb/tb_fir_stim_gen.sv
// Testbench for fir_stim_gen: directed scenarios plus randomized bursts
// compared against a plain-arithmetic model of the waveform rules.
module tb_fir_stim_gen;

    logic        clk = 1'b0;
    logic        nrst;
    logic        start;
    logic [1:0]  mode;
    logic [15:0] amp;
    logic [15:0] len;
    logic [15:0] seed;
    logic        abort;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;
    logic [15:0] sample_cnt;

    int total = 0;
    int bad   = 0;

    // Results of the most recent burst.
    logic [15:0] got_data[$];
    logic        got_last[$];
    int n_xfer, done_seen, done_lat, stable_err, busy_err, valid_at_done, abort_xfer;
    bit pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    fir_stim_gen #(.DATA_W(16), .LEN_W(16)) dut (
        .clk(clk), .nrst(nrst), .start(start), .mode(mode), .amp(amp),
        .len(len), .seed(seed), .abort(abort), .out_ready(out_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done), .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    // Expected sample i of a burst, straight from the waveform definitions.
    function automatic logic [15:0] model_sample(input logic [1:0] m, input logic [15:0] a,
                                                 input logic [15:0] s, input int i);
        logic [15:0] l;
        logic [31:0] p;
        model_sample = 16'h0000;
        case (m)
            2'd0: model_sample = (i == 0) ? a : 16'h0000;
            2'd1: model_sample = a;
            2'd2: begin
                p = 32'(i) * 32'(a);
                model_sample = p[15:0];
            end
            default: begin
                l = (s == 16'h0000) ? 16'hACE1 : s;
                for (int k = 0; k < i; k++) begin
                    l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
                end
                model_sample = l;
            end
        endcase
    endfunction

    // Drive one burst; rmode 0 = always ready, 1 = random ready, 2 = fixed pattern.
    task automatic run_burst(input logic [1:0] m, input logic [15:0] a, input logic [15:0] l,
                             input logic [15:0] s, input int rmode, input int abort_after,
                             input int poke_start);
        int cyc;
        int ev;
        int prev_stall;
        logic [15:0] pd;
        logic pl;
        logic r;
        got_data.delete();
        got_last.delete();
        n_xfer = 0; done_seen = 0; done_lat = -1; stable_err = 0; busy_err = 0;
        valid_at_done = 0; abort_xfer = 0; prev_stall = 0; pd = '0; pl = 1'b0;
        @(negedge clk);
        mode = m; amp = a; len = l; seed = s; start = 1'b1; abort = 1'b0;
        @(negedge clk);
        start = 1'b0;
        mode = 2'($urandom); amp = 16'($urandom); len = 16'($urandom); seed = 16'($urandom);
        cyc = 1;
        ev  = 0;
        while (cyc < 3000) begin
            if (done) begin
                done_seen = 1;
                done_lat = cyc - ev;
                valid_at_done = int'(out_valid);
                break;
            end
            if (busy !== out_valid) busy_err++;
            if (out_valid && prev_stall != 0 && (out_data !== pd || out_last !== pl)) stable_err++;
            case (rmode)
                0:       r = 1'b1;
                1:       r = ($urandom_range(0, 9) < 7);
                default: r = pat[(cyc - 1) % 5];
            endcase
            abort = (abort_after >= 0 && n_xfer == abort_after && out_valid);
            if (abort && rmode == 0) r = 1'b0;
            start = (poke_start != 0) && ($urandom_range(0, 5) == 0);
            out_ready = r;
            if (out_valid && r) begin
                got_data.push_back(out_data);
                got_last.push_back(out_last);
                n_xfer++;
                prev_stall = 0;
                if (out_last) ev = cyc;
                if (abort) abort_xfer = 1;
            end else if (out_valid) begin
                prev_stall = 1;
                pd = out_data;
                pl = out_last;
            end
            if (abort) ev = cyc;
            @(negedge clk);
            cyc++;
        end
        abort = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
        $display("burst mode=%0d len=%0d xfers=%0d sample_cnt=%0d done_lat=%0d",
                 m, l, n_xfer, sample_cnt, done_lat);
    endtask

    task automatic test_reset();
        nrst = 1'b0; start = 0; mode = 0; amp = 0; len = 0; seed = 0; abort = 0; out_ready = 0;
        #1;
        total++;
        if ({out_valid, out_data, out_last, busy, done, sample_cnt} !== 36'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0",
                     {out_valid, out_data, out_last, busy, done, sample_cnt});
        end
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({out_valid, busy, done} !== 3'b000) begin
            bad++;
            $display("FAIL idle_after_reset: got %b want 000", {out_valid, busy, done});
        end
    endtask

    task automatic test_impulse();
        logic [15:0] exp_d [4];
        exp_d = '{16'h0100, 16'h0000, 16'h0000, 16'h0000};
        run_burst(2'd0, 16'h0100, 16'd4, 16'h0, 0, -1, 0);
        total++;
        if (n_xfer !== 4) begin bad++; $display("FAIL impulse_count: got %0d want 4", n_xfer); end
        for (int i = 0; i < n_xfer && i < 4; i++) begin
            total++;
            if (got_data[i] !== exp_d[i] || got_last[i] !== (i == 3)) begin
                bad++;
                $display("FAIL impulse_sample%0d: got %h/%b want %h/%b", i, got_data[i], got_last[i],
                         exp_d[i], (i == 3));
            end
        end
        total++;
        if (done_seen !== 1 || done_lat !== 1 || valid_at_done !== 0) begin
            bad++;
            $display("FAIL impulse_done: seen=%0d lat=%0d valid=%0d want 1/1/0", done_seen, done_lat, valid_at_done);
        end
        total++;
        if (sample_cnt !== 16'd4) begin bad++; $display("FAIL impulse_cnt: got %0d want 4", sample_cnt); end
        @(negedge clk);
        total++;
        if ({done, busy} !== 2'b00) begin bad++; $display("FAIL impulse_done_width: got %b want 00", {done, busy}); end
    endtask

    task automatic test_ramp_wrap();
        logic [15:0] exp_d [6];
        exp_d = '{16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'h0000, 16'h4000};
        run_burst(2'd2, 16'h4000, 16'd6, 16'h0, 0, -1, 1);
        total++;
        if (n_xfer !== 6 || done_seen !== 1) begin
            bad++; $display("FAIL ramp_count: got %0d done=%0d want 6 done=1", n_xfer, done_seen);
        end
        for (int i = 0; i < n_xfer && i < 6; i++) begin
            total++;
            if (got_data[i] !== exp_d[i] || got_last[i] !== (i == 5)) begin
                bad++;
                $display("FAIL ramp_sample%0d: got %h/%b want %h/%b", i, got_data[i], got_last[i], exp_d[i], (i == 5));
            end
        end
    endtask

    task automatic test_backpressure();
        run_burst(2'd1, 16'h7FFF, 16'd3, 16'h0, 2, -1, 0);
        total++;
        if (n_xfer !== 3 || sample_cnt !== 16'd3) begin
            bad++; $display("FAIL bp_count: got %0d cnt=%0d want 3", n_xfer, sample_cnt);
        end
        for (int i = 0; i < n_xfer && i < 3; i++) begin
            total++;
            if (got_data[i] !== 16'h7FFF || got_last[i] !== (i == 2)) begin
                bad++; $display("FAIL bp_sample%0d: got %h/%b want 7fff/%b", i, got_data[i], got_last[i], (i == 2));
            end
        end
        total++;
        if (stable_err !== 0 || busy_err !== 0) begin
            bad++; $display("FAIL bp_stable: got stable_err=%0d busy_err=%0d want 0/0", stable_err, busy_err);
        end
        total++;
        if (done_seen !== 1 || done_lat !== 1) begin
            bad++; $display("FAIL bp_done: seen=%0d lat=%0d want 1/1", done_seen, done_lat);
        end
    endtask

    task automatic test_lfsr();
        run_burst(2'd3, 16'h0, 16'd5, 16'h0000, 0, -1, 0);
        total++;
        if (n_xfer !== 5) begin bad++; $display("FAIL lfsr_count: got %0d want 5", n_xfer); end
        if (n_xfer >= 2) begin
            total++;
            if (got_data[0] !== 16'hACE1 || got_data[1] !== 16'hE270) begin
                bad++; $display("FAIL lfsr_first: got %h %h want ace1 e270", got_data[0], got_data[1]);
            end
        end
        for (int i = 2; i < n_xfer; i++) begin
            total++;
            if (got_data[i] !== model_sample(2'd3, 16'h0, 16'h0, i)) begin
                bad++; $display("FAIL lfsr_sample%0d: got %h want %h", i, got_data[i], model_sample(2'd3, 16'h0, 16'h0, i));
            end
        end
    endtask

    task automatic test_len_zero_abort();
        run_burst(2'd1, 16'h1234, 16'd0, 16'h0, 0, -1, 0);
        total++;
        if (n_xfer !== 0 || done_seen !== 1 || done_lat !== 1 || sample_cnt !== 16'd0) begin
            bad++; $display("FAIL len0: got xfers=%0d done=%0d lat=%0d cnt=%0d want 0/1/1/0",
                            n_xfer, done_seen, done_lat, sample_cnt);
        end
        run_burst(2'd2, 16'h0011, 16'd10, 16'h0, 0, 3, 0);
        total++;
        if (n_xfer !== 3 || sample_cnt !== 16'd3) begin
            bad++; $display("FAIL abort_count: got %0d cnt=%0d want 3", n_xfer, sample_cnt);
        end
        total++;
        if (done_seen !== 1 || done_lat !== 1 || valid_at_done !== 0) begin
            bad++; $display("FAIL abort_done: seen=%0d lat=%0d valid=%0d want 1/1/0", done_seen, done_lat, valid_at_done);
        end
        abort = 1'b1;
        repeat (5) @(negedge clk);
        abort = 1'b0;
        total++;
        if (sample_cnt !== 16'd3 || out_valid !== 1'b0) begin
            bad++; $display("FAIL cnt_hold: got cnt=%0d valid=%b want 3/0", sample_cnt, out_valid);
        end
    endtask

    task automatic test_reset_mid_burst();
        int seen;
        @(negedge clk);
        mode = 2'd2; amp = 16'd3; len = 16'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #2 nrst = 1'b0;
        #1;
        total++;
        if ({out_valid, out_data, out_last, busy, done, sample_cnt} !== 36'd0) begin
            bad++; $display("FAIL async_reset: got %h want 0", {out_valid, out_data, out_last, busy, done, sample_cnt});
        end
        @(negedge clk);
        nrst = 1'b1;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || out_valid) seen++;
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL reset_discard: got %0d active cycles want 0", seen); end
        run_burst(2'd2, 16'h0123, 16'd8, 16'h0, 1, -1, 0);
        total++;
        if (n_xfer !== 8 || sample_cnt !== 16'd8 || done_seen !== 1) begin
            bad++; $display("FAIL post_reset_burst: got %0d cnt=%0d done=%0d want 8/8/1", n_xfer, sample_cnt, done_seen);
        end
        for (int i = 0; i < n_xfer; i++) begin
            total++;
            if (got_data[i] !== model_sample(2'd2, 16'h0123, 16'h0, i)) begin
                bad++; $display("FAIL post_reset_sample%0d: got %h want %h", i, got_data[i], model_sample(2'd2, 16'h0123, 16'h0, i));
            end
        end
    endtask

    task automatic test_random();
        logic [1:0]  m;
        logic [15:0] a;
        logic [15:0] s;
        int l;
        int ab;
        int exp_n;
        for (int b = 0; b < 25; b++) begin
            m  = 2'($urandom);
            a  = 16'($urandom);
            s  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            l  = $urandom_range(0, 12);
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 12) : -1;
            run_burst(m, a, 16'(l), s, 1, ab, 1);
            exp_n = (ab >= 0 && ab < l) ? ab + abort_xfer : l;
            total++;
            if (n_xfer !== exp_n || sample_cnt !== 16'(exp_n)) begin
                bad++; $display("FAIL rand%0d_count: got %0d cnt=%0d want %0d", b, n_xfer, sample_cnt, exp_n);
            end
            total++;
            if (done_seen !== 1 || done_lat !== 1 || stable_err !== 0 || busy_err !== 0) begin
                bad++; $display("FAIL rand%0d_proto: done=%0d lat=%0d stable=%0d busy=%0d want 1/1/0/0",
                                b, done_seen, done_lat, stable_err, busy_err);
            end
            for (int i = 0; i < n_xfer; i++) begin
                total++;
                if (got_data[i] !== model_sample(m, a, s, i) || got_last[i] !== (i == l - 1)) begin
                    bad++; $display("FAIL rand%0d_sample%0d: got %h/%b want %h/%b", b, i, got_data[i], got_last[i],
                                    model_sample(m, a, s, i), (i == l - 1));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_ramp_wrap();
        test_backpressure();
        test_lfsr();
        test_len_zero_abort();
        test_reset_mid_burst();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
